plab1_imul_mul_arbiter: RTL and testbench

//  Shares one val/rdy integer multiplier (variable-latency, one transaction in flight)

---
 rtl/plab1_imul_mul_arbiter_pkg.sv | 22 ++
 rtl/plab1_imul_rr_arb.sv | 33 +++
 rtl/plab1_imul_mul_arbiter.sv | 109 ++++++++++
 tb/tb_plab1_imul_mul_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plab1_imul_mul_arbiter_pkg.sv
// Shared widths, FSM encodings and request-packing helper for the
// multiplier arbiter slice.
package plab1_imul_mul_arbiter_pkg;

  localparam int FUNC_NB = 3;
  localparam int DATA_NB = 32;
  localparam int REQ_NB  = FUNC_NB + 2 * DATA_NB;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic logic [REQ_NB-1:0] mk_req(
    input logic [FUNC_NB-1:0] f,
    input logic [DATA_NB-1:0] a,
    input logic [DATA_NB-1:0] b
  );
    return {f, a, b};
  endfunction

endpackage

// File: rtl/plab1_imul_rr_arb.sv
// Round-robin picker: first requester at or after prio_ptr wins.
// Outputs one-hot grant, its index, and whether anything won.
module plab1_imul_rr_arb #(
  parameter int P_NREQS = 2,
  parameter int P_TAG_NB = 1
) (
  input  logic [P_NREQS-1:0]  reqs,
  input  logic [P_TAG_NB-1:0] prio_ptr,
  input  logic                en,
  output logic [P_NREQS-1:0]  grant,
  output logic [P_TAG_NB-1:0] grant_idx,
  output logic                grant_val
);

  // Scan from the priority pointer, wrapping once around the ring.
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    grant_idx = '0;
    grant_val = 1'b0;
    for (int k = 0; k < P_NREQS; k++) begin
      j = int'(prio_ptr) + k;
      if (j >= P_NREQS) j = j - P_NREQS;
      if (en && !grant_val && reqs[j]) begin
        grant_val = 1'b1;
        grant[j] = 1'b1;
        grant_idx = P_TAG_NB'(j);
      end
    end
  end

endmodule

// File: rtl/plab1_imul_mul_arbiter.sv
// Shares one val/rdy multiplier among p_nreqs requesters with
// round-robin grant and a single transaction in flight.
module plab1_imul_mul_arbiter
  import plab1_imul_mul_arbiter_pkg::*;
#(
  parameter int p_nreqs = 2,
  parameter int p_tag_nb = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [p_nreqs-1:0]        in_val,
  output logic [p_nreqs-1:0]        in_rdy,
  input  logic [p_nreqs*REQ_NB-1:0] in_msg,
  output logic [p_nreqs-1:0]        out_val,
  input  logic [p_nreqs-1:0]        out_rdy,
  output logic [DATA_NB-1:0]        out_msg,
  output logic                      mul_req_val,
  input  logic                      mul_req_rdy,
  output logic [REQ_NB-1:0]         mul_req_msg,
  input  logic                      mul_resp_val,
  output logic                      mul_resp_rdy,
  input  logic [DATA_NB-1:0]        mul_resp_msg
);

  logic [1:0]          state_q, state_d;
  logic [p_tag_nb-1:0] prio_q, prio_d;
  logic [p_tag_nb-1:0] owner_q, owner_d;
  logic [REQ_NB-1:0]   req_buf_q;
  logic [DATA_NB-1:0]  resp_buf_q;
  logic                req_en, resp_en;

  logic [p_nreqs-1:0]  gnt;
  logic [p_tag_nb-1:0] gnt_idx;
  logic                gnt_val;
  logic [p_nreqs-1:0]  one_hot;

  plab1_imul_rr_arb #(
    .P_NREQS  (p_nreqs),
    .P_TAG_NB (p_tag_nb)
  ) u_arb (
    .reqs      (in_val),
    .prio_ptr  (prio_q),
    .en        (state_q == ST_IDLE),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_val (gnt_val)
  );

  // Next-state, buffer enables and pointer/owner update.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    req_en  = 1'b0;
    resp_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_val) begin
          req_en  = 1'b1;
          owner_d = gnt_idx;
          if (gnt_idx == p_tag_nb'(p_nreqs - 1))
            prio_d = '0;
          else
            prio_d = gnt_idx + p_tag_nb'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: if (mul_req_rdy) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mul_resp_val) begin
          resp_en = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (out_rdy[owner_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, round-robin pointer and current owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      prio_q  <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  // Data buffers are not reset; they are only observed with a valid.
  always_ff @(posedge clk) begin
    if (req_en)
      req_buf_q <= in_msg[int'(gnt_idx)*REQ_NB +: REQ_NB];
    if (resp_en)
      resp_buf_q <= mul_resp_msg;
  end

  assign one_hot      = p_nreqs'(1) << owner_q;
  assign in_rdy       = gnt;
  assign mul_req_val  = (state_q == ST_ISSUE);
  assign mul_req_msg  = req_buf_q;
  assign mul_resp_rdy = (state_q == ST_WAIT);
  assign out_val      = (state_q == ST_RESP) ? one_hot : '0;
  assign out_msg      = resp_buf_q;

endmodule

// File: tb/tb_plab1_imul_mul_arbiter.sv
// Directed and randomized bench for the multiplier arbiter,
// four requesters, bench-side multiplier model.
module tb_plab1_imul_mul_arbiter;
  import plab1_imul_mul_arbiter_pkg::*;

  localparam int N = 4;
  localparam int T = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      in_val = '0;
  logic [N-1:0]      in_rdy;
  logic [N*REQ_NB-1:0] in_msg = '0;
  logic [N-1:0]      out_val;
  logic [N-1:0]      out_rdy = '0;
  logic [31:0]       out_msg;
  logic              mul_req_val;
  logic              mul_req_rdy = 1'b0;
  logic [REQ_NB-1:0] mul_req_msg;
  logic              mul_resp_val = 1'b0;
  logic              mul_resp_rdy;
  logic [31:0]       mul_resp_msg = '0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  plab1_imul_mul_arbiter #(
    .p_nreqs  (N),
    .p_tag_nb (T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_msg       (in_msg),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_msg      (out_msg),
    .mul_req_val  (mul_req_val),
    .mul_req_rdy  (mul_req_rdy),
    .mul_req_msg  (mul_req_msg),
    .mul_resp_val (mul_resp_val),
    .mul_resp_rdy (mul_resp_rdy),
    .mul_resp_msg (mul_resp_msg)
  );

  task automatic check(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int p, input logic [REQ_NB-1:0] m);
    in_msg[p*REQ_NB +: REQ_NB] = m;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_val = '0;
    out_rdy = '0;
    mul_req_rdy = 1'b0;
    mul_resp_val = 1'b0;
    step();
    step();
    check("rst_in_rdy", 96'(in_rdy), 96'(0));
    check("rst_out_val", 96'(out_val), 96'(0));
    check("rst_req_val", 96'(mul_req_val), 96'(0));
    check("rst_resp_rdy", 96'(mul_resp_rdy), 96'(0));
    reset = 1'b0;
    #1;
  endtask

  // From ISSUE: accept the request, return product p, end in RESP.
  task automatic serve_mul(input logic [31:0] p);
    mul_req_rdy = 1'b1;
    step();
    mul_req_rdy = 1'b0;
    mul_resp_val = 1'b1;
    mul_resp_msg = p;
    step();
    mul_resp_val = 1'b0;
    #1;
  endtask

  // Random-test state
  localparam int PER_PORT = 50;
  logic [31:0]       ra [N];
  logic [31:0]       rb [N];
  int                sent [N];
  int                got_cnt;
  int                acc_port;
  logic [31:0]       acc_prod;
  logic [REQ_NB-1:0] acc_msg;
  logic [REQ_NB-1:0] mreq;
  logic [31:0]       mprod;
  int                mstate;
  int                mdelay;
  logic [REQ_NB-1:0] m;

  initial begin
    // 1: single request on port 0
    do_reset();
    m = mk_req(3'd0, 32'd3, 32'd4);
    set_msg(0, m);
    in_val = 4'b0001;
    #1;
    check("t1_in_rdy", 96'(in_rdy), 96'(4'b0001));
    step();
    in_val = '0;
    check("t1_req_val", 96'(mul_req_val), 96'(1));
    check("t1_req_msg", 96'(mul_req_msg), 96'(m));
    serve_mul(32'd12);
    check("t1_out_val", 96'(out_val), 96'(4'b0001));
    check("t1_out_msg", 96'(out_msg), 96'(12));
    out_rdy = 4'b0001;
    step();
    out_rdy = '0;
    check("t1_done", 96'(out_val), 96'(0));

    // 2: ports 0/1 always valid, grants alternate
    do_reset();
    for (int k = 0; k < 6; k++) begin
      int e;
      int j;
      logic [31:0] a0, b0, a1, b1, pr;
      e = k % 2;
      j = k / 2;
      a0 = 32'(j + 2);
      b0 = 32'(j + 3);
      a1 = 32'(10 + j + 2);
      b1 = 32'(j + 3);
      set_msg(0, mk_req(3'd0, a0, b0));
      set_msg(1, mk_req(3'd0, a1, b1));
      pr = (e == 0) ? a0 * b0 : a1 * b1;
      in_val = 4'b0011;
      #1;
      check("t2_grant", 96'(in_rdy), 96'(4'b0001 << e));
      step();
      check("t2_busy_rdy", 96'(in_rdy), 96'(0));
      check("t2_req_msg", 96'(mul_req_msg),
            96'(mk_req(3'd0, e == 0 ? a0 : a1, e == 0 ? b0 : b1)));
      serve_mul(pr);
      check("t2_out_val", 96'(out_val), 96'(4'b0001 << e));
      check("t2_out_msg", 96'(out_msg), 96'(pr));
      out_rdy = 4'b0001 << e;
      step();
      out_rdy = '0;
    end
    in_val = '0;

    // 3: backpressure on both sides
    do_reset();
    m = mk_req(3'd0, 32'h7, 32'h9);
    set_msg(0, m);
    in_val = 4'b0001;
    step();
    in_val = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      check("t3_req_hold", 96'(mul_req_val), 96'(1));
      check("t3_req_msg", 96'(mul_req_msg), 96'(m));
      check("t3_in_rdy", 96'(in_rdy), 96'(0));
      step();
    end
    serve_mul(32'd63);
    for (int c = 0; c < 7; c++) begin
      check("t3_out_hold", 96'(out_val), 96'(4'b0001));
      check("t3_out_msg", 96'(out_msg), 96'(63));
      check("t3_in_rdy2", 96'(in_rdy), 96'(0));
      step();
    end
    in_val = '0;
    out_rdy = 4'b0001;
    step();
    out_rdy = '0;
    check("t3_once_a", 96'(out_val), 96'(0));
    step();
    check("t3_once_b", 96'(out_val), 96'(0));
    check("t3_idle_req", 96'(mul_req_val), 96'(0));

    // 4: non-owner out_rdy ignored; stray resp_val in IDLE
    do_reset();
    set_msg(1, mk_req(3'd0, 32'd5, 32'd6));
    in_val = 4'b0010;
    #1;
    check("t4_grant", 96'(in_rdy), 96'(4'b0010));
    step();
    in_val = '0;
    serve_mul(32'd30);
    out_rdy = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      step();
      check("t4_hold", 96'(out_val), 96'(4'b0010));
      check("t4_msg", 96'(out_msg), 96'(30));
    end
    out_rdy = 4'b0010;
    step();
    out_rdy = '0;
    check("t4_done", 96'(out_val), 96'(0));
    mul_resp_val = 1'b1;
    mul_resp_msg = 32'd99;
    #1;
    check("t4_stray_rdy", 96'(mul_resp_rdy), 96'(0));
    step();
    check("t4_stray_rdy2", 96'(mul_resp_rdy), 96'(0));
    check("t4_stray_out", 96'(out_val), 96'(0));
    mul_resp_val = 1'b0;

    // 5: reset while waiting for the product
    do_reset();
    set_msg(0, mk_req(3'd0, 32'd1, 32'd1));
    in_val = 4'b0001;
    step();
    in_val = '0;
    mul_req_rdy = 1'b1;
    step();
    mul_req_rdy = 1'b0;
    check("t5_wait", 96'(mul_resp_rdy), 96'(1));
    reset = 1'b1;
    step();
    check("t5_out_val", 96'(out_val), 96'(0));
    check("t5_req_val", 96'(mul_req_val), 96'(0));
    check("t5_resp_rdy", 96'(mul_resp_rdy), 96'(0));
    check("t5_in_rdy", 96'(in_rdy), 96'(0));
    reset = 1'b0;
    m = mk_req(3'd0, 32'hFFFF_FFFF, 32'd2);
    set_msg(1, m);
    in_val = 4'b0011;
    #1;
    check("t5_ptr0", 96'(in_rdy), 96'(4'b0001));
    in_val = 4'b0010;
    #1;
    check("t5_grant1", 96'(in_rdy), 96'(4'b0010));
    step();
    in_val = '0;
    check("t5_req_msg", 96'(mul_req_msg), 96'(m));
    serve_mul(32'hFFFF_FFFF * 32'd2);
    check("t5_out_val2", 96'(out_val), 96'(4'b0010));
    check("t5_out_msg", 96'(out_msg), 96'(32'hFFFF_FFFE));
    out_rdy = 4'b0010;
    step();
    out_rdy = '0;

    // 6: random sources, sinks and multiplier latency
    do_reset();
    for (int i = 0; i < N; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      sent[i] = 0;
    end
    got_cnt = 0;
    acc_port = 0;
    acc_prod = '0;
    acc_msg = '0;
    mprod = '0;
    mstate = 0;
    mdelay = 0;
    for (int cyc = 0; cyc < 20000 && got_cnt < N * PER_PORT; cyc++) begin
      for (int i = 0; i < N; i++) begin
        in_val[i] = (sent[i] < PER_PORT) && ($urandom_range(2) != 0);
        set_msg(i, mk_req(3'd0, ra[i], rb[i]));
      end
      out_rdy = 4'($urandom);
      mul_req_rdy = (mstate == 0) && ($urandom_range(1) == 1);
      mul_resp_val = (mstate == 1) && (mdelay == 0);
      mul_resp_msg = mprod;
      #1;
      for (int i = 0; i < N; i++) begin
        if (in_val[i] && in_rdy[i]) begin
          acc_port = i;
          acc_prod = ra[i] * rb[i];
          acc_msg = mk_req(3'd0, ra[i], rb[i]);
          ra[i] = $urandom;
          rb[i] = $urandom;
          sent[i]++;
        end
      end
      if (mul_req_val && mul_req_rdy) begin
        check("t6_req_msg", 96'(mul_req_msg), 96'(acc_msg));
        mreq = mul_req_msg;
        mprod = mreq[63:32] * mreq[31:0];
        mstate = 1;
        mdelay = $urandom_range(3);
      end else if (mul_resp_val && mul_resp_rdy) begin
        mstate = 0;
      end else if (mstate == 1 && mdelay > 0) begin
        mdelay--;
      end
      if ((out_val & out_rdy) != '0) begin
        check("t6_port", 96'(out_val), 96'(4'b0001 << acc_port));
        check("t6_prod", 96'(out_msg), 96'(acc_prod));
        got_cnt++;
      end
      step();
    end
    check("t6_count", 96'(got_cnt), 96'(N * PER_PORT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
